lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_if.sv | 47 ++++
 rtl/lsu_ctrl.sv | 148 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl_if
//  Description : Bundles the pipeline request/response handshake and the
//                data-memory port of the load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsu_ctrl_if;
  // pipeline request
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  // data memory
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_we_o;
  logic [1:0]  mem_hb_o;
  logic        mem_uload_o;
  logic [31:0] mem_rdata_i;
  // pipeline response
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] rsp_badaddr_o;

  // LSU side
  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
           req_wdata_i, mem_rdata_i, rsp_ready_i,
    output req_ready_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_hb_o,
           mem_uload_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_badaddr_o
  );

  // pipeline + memory side
  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
           req_wdata_i, mem_rdata_i, rsp_ready_i,
    input  req_ready_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_hb_o,
           mem_uload_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_badaddr_o
  );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl
//  Description : Single-outstanding load/store controller. Accepts one request
//                in IDLE, checks alignment/range, performs a one-cycle memory
//                access and returns a response with valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  wire logic   clk_i,
  input  wire logic   rst_i,
  lsu_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] badaddr_q, badaddr_d;

  logic [2:0]  acc_bytes;
  logic [32:0] end_addr;
  logic        fault;

  // Fault decision on the incoming request; the end address is computed in
  // 33 bits so an access near 0xFFFFFFFF cannot wrap back into range.
  always_comb begin
    acc_bytes = 3'd0;
    case (bus.req_size_i)
      2'b00:   acc_bytes = 3'd4;
      2'b01:   acc_bytes = 3'd1;
      2'b10:   acc_bytes = 3'd2;
      default: acc_bytes = 3'd0;
    endcase
    end_addr = {1'b0, bus.req_addr_i} + {30'd0, acc_bytes};
    fault    = (bus.req_size_i == 2'b11)
             | ((bus.req_size_i == 2'b10) & bus.req_addr_i[0])
             | ((bus.req_size_i == 2'b00) & (bus.req_addr_i[1:0] != 2'b00))
             | (end_addr > 33'(MEM_BYTES));
  end

  // State, holding and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      badaddr_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      badaddr_q <= badaddr_d;
    end
  end

  // Next-state and output decode; every output is forced idle during reset so
  // a store caught in ACCESS never commits.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    badaddr_d = badaddr_q;

    bus.req_ready_o   = 1'b0;
    bus.rsp_valid_o   = 1'b0;
    bus.mem_addr_o    = '0;
    bus.mem_wdata_o   = '0;
    bus.mem_we_o      = 1'b0;
    bus.mem_hb_o      = 2'b11;
    bus.mem_uload_o   = 1'b0;
    bus.rsp_rdata_o   = rst_i ? 32'd0 : rdata_q;
    bus.rsp_err_o     = rst_i ? 1'b0  : err_q;
    bus.rsp_badaddr_o = rst_i ? 32'd0 : badaddr_q;

    case (state_q)
      IDLE: begin
        bus.req_ready_o = ~rst_i;
        if (bus.req_valid_i) begin
          addr_d  = bus.req_addr_i;
          we_d    = bus.req_we_i;
          size_d  = bus.req_size_i;
          uns_d   = bus.req_unsigned_i;
          wdata_d = bus.req_wdata_i;
          if (fault) begin
            rdata_d   = '0;
            err_d     = 1'b1;
            badaddr_d = bus.req_addr_i;
            state_d   = RESP;
          end else begin
            state_d   = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!rst_i) begin
          bus.mem_addr_o  = addr_q;
          bus.mem_wdata_o = wdata_q;
          bus.mem_we_o    = we_q;
          bus.mem_hb_o    = size_q;
          bus.mem_uload_o = uns_q;
        end
        rdata_d   = we_q ? 32'd0 : bus.mem_rdata_i;
        err_d     = 1'b0;
        badaddr_d = '0;
        state_d   = RESP;
      end
      RESP: begin
        bus.rsp_valid_o = ~rst_i;
        if (bus.rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_ctrl
//  Description : Scoreboard bench for lsu_ctrl with a byte-array data memory
//                and a behavioural reference model of the load/store rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;
  localparam int MEM_BYTES = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_ctrl_if bus ();

  lsu_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] bad;
  } rsp_t;

  rsp_t        exp_q[$];
  rsp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_writes = 0;
  int          exp_writes = 0;

  logic [7:0]  mem     [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [9:0]  ma;
  logic [7:0]  rb;
  logic [15:0] rh;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Data memory: combinational, already-extended read; lane write on the edge.
  assign ma = bus.mem_addr_o[9:0];
  always_comb begin
    rb = mem[ma];
    rh = {mem[ma + 10'd1], mem[ma]};
    case (bus.mem_hb_o)
      2'b00:   bus.mem_rdata_i = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};
      2'b01:   bus.mem_rdata_i = bus.mem_uload_o ? {24'd0, rb} : {{24{rb[7]}}, rb};
      2'b10:   bus.mem_rdata_i = bus.mem_uload_o ? {16'd0, rh} : {{16{rh[15]}}, rh};
      default: bus.mem_rdata_i = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.mem_we_o) begin
      case (bus.mem_hb_o)
        2'b00: begin
          mem[ma]         <= bus.mem_wdata_o[7:0];
          mem[ma + 10'd1] <= bus.mem_wdata_o[15:8];
          mem[ma + 10'd2] <= bus.mem_wdata_o[23:16];
          mem[ma + 10'd3] <= bus.mem_wdata_o[31:24];
        end
        2'b01: mem[ma] <= bus.mem_wdata_o[7:0];
        2'b10: begin
          mem[ma]         <= bus.mem_wdata_o[7:0];
          mem[ma + 10'd1] <= bus.mem_wdata_o[15:8];
        end
        default: ;
      endcase
    end
  end

  // Monitor: pops the expected response whenever the DUT hands one over.
  always @(negedge clk) begin
    if (bus.mem_we_o) n_writes++;
    if (!rst && bus.rsp_valid_o && bus.rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_rdata", bus.rsp_rdata_o, mon_e.rdata);
        check("rsp_err", {31'd0, bus.rsp_err_o}, {31'd0, mon_e.err});
        check("rsp_badaddr", bus.rsp_badaddr_o, mon_e.bad);
      end
    end
  end

  // Reference model: memory as a plain byte array, rules applied directly.
  task automatic model(input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, output rsp_t r);
    int          n;
    logic [63:0] endp;
    logic [31:0] v;
    bit          flt;
    n    = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 0;
    endp = {32'd0, a} + 64'(n);
    flt  = (sz == 2'd3) || (sz == 2'd2 && a[0]) || (sz == 2'd0 && a[1:0] != 2'd0)
           || (endp > 64'(MEM_BYTES));
    r = '0;
    if (flt) begin
      r.err = 1'b1;
      r.bad = a;
    end else if (we) begin
      for (int i = 0; i < n; i++) ref_mem[a[9:0] + 10'(i)] = wd[8*i +: 8];
      exp_writes++;
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a[9:0] + 10'(i)];
      if (!u && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (!u && n == 2) v = {{16{v[15]}}, v[15:0]};
      r.rdata = v;
    end
  endtask

  // Issue one request, check latency, optionally hold back-pressure for bp cycles.
  task automatic issue(input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input int bp);
    rsp_t e;
    int   k;
    @(negedge clk);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = u;
    bus.req_addr_i     = a;
    bus.req_wdata_i    = wd;
    k = 0;
    while (!bus.req_ready_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready_o) begin
      check("req_ready_timeout", 32'd0, 32'd1);
      bus.req_valid_i = 1'b0;
      return;
    end
    model(we, sz, u, a, wd, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.rsp_ready_i    = (bp == 0);
    bus.req_valid_i    = 1'($urandom_range(0, 1));
    bus.req_we_i       = 1'($urandom_range(0, 1));
    bus.req_addr_i     = $urandom;
    bus.req_size_i     = 2'($urandom_range(0, 3));
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.rsp_valid_o && k < 10);
    check("rsp_latency", 32'(k), e.err ? 32'd1 : 32'd2);
    for (int i = 0; i < bp; i++) begin
      check("bp_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
      check("bp_req_ready", {31'd0, bus.req_ready_o}, 32'd0);
      check("bp_rdata", bus.rsp_rdata_o, e.rdata);
      check("bp_badaddr", bus.rsp_badaddr_o, e.bad);
      @(posedge clk);
      #1;
      if (i == bp - 1) bus.rsp_ready_i = 1'b1;
      @(negedge clk);
    end
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    check("idle_after_rsp", {31'd0, bus.req_ready_o}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          diffs;
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = 1'b0;
    bus.req_size_i     = 2'd0;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i     = 32'd0;
    bus.req_wdata_i    = 32'd0;
    bus.rsp_ready_i    = 1'b1;

    repeat (2) @(negedge clk);
    bus.req_valid_i = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'd0, bus.req_ready_o}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    check("rst_rsp_err", {31'd0, bus.rsp_err_o}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata_o, 32'd0);
    check("rst_rsp_badaddr", bus.rsp_badaddr_o, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we_o}, 32'd0);
    check("rst_mem_hb", {30'd0, bus.mem_hb_o}, 32'd3);
    bus.req_valid_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // word store then load
    issue(1'b1, 2'd0, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    issue(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 0);
    // sub-word loads
    issue(1'b1, 2'd0, 1'b0, 32'h20, 32'h80FF7F01, 0);
    issue(1'b0, 2'd1, 1'b0, 32'h23, 32'h0, 0);
    issue(1'b0, 2'd1, 1'b1, 32'h23, 32'h0, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 0);
    issue(1'b0, 2'd2, 1'b1, 32'h20, 32'h0, 0);
    // faults and range edges
    issue(1'b1, 2'd0, 1'b0, 32'h12, 32'h12345678, 0);
    issue(1'b0, 2'd0, 1'b0, 32'h400, 32'h0, 0);
    issue(1'b0, 2'd0, 1'b0, 32'hFFFFFFFC, 32'h0, 0);
    issue(1'b1, 2'd0, 1'b0, 32'h3FC, 32'hCAFEF00D, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h3FE, 32'h0, 0);
    issue(1'b0, 2'd1, 1'b1, 32'h3FF, 32'h0, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h3FF, 32'h0, 0);
    issue(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 0);
    issue(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 0);
    // back-pressure
    issue(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 5);

    // reset during the ACCESS cycle of a byte store
    issue(1'b1, 2'd0, 1'b0, 32'h30, 32'h11223344, 0);
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_size_i  = 2'd1;
    bus.req_addr_i  = 32'h30;
    bus.req_wdata_i = 32'hAA;
    check("rmid_ready", {31'd0, bus.req_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    check("rmid_mem_we", {31'd0, bus.mem_we_o}, 32'd0);
    check("rmid_mem_hb", {30'd0, bus.mem_hb_o}, 32'd3);
    check("rmid_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rmid_idle", {31'd0, bus.req_ready_o}, 32'd1);
    check("rmid_no_rsp", {31'd0, bus.rsp_valid_o}, 32'd0);
    check("rmid_byte", {24'd0, mem[32'h30]}, 32'h44);
    issue(1'b0, 2'd0, 1'b0, 32'h30, 32'h0, 0);

    // randomized traffic
    for (int t = 0; t < 120; t++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 7))
        0:       a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
        1:       a = 32'(MEM_BYTES - 4) + 32'($urandom_range(0, 7));
        default: a = 32'($urandom_range(0, MEM_BYTES - 1));
      endcase
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd0) a[1:0] = 2'd0;
        if (sz == 2'd2) a[0] = 1'b0;
      end
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    repeat (3) @(negedge clk);
    check("write_count", 32'(n_writes), 32'(exp_writes));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    diffs = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("mem_image_diffs", 32'(diffs), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
